// File: rtl/approx_mult_seq_ctrl.sv
// approx_mult_seq_ctrl: shift-and-add controller with hybrid approximate/exact accumulation and adder clock-gate enables; optional ZERO_SKIP_EN bypasses zero operands
module approx_mult_seq_ctrl #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_exact,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy,
    output logic               cg_en_exact,
    output logic               cg_en_approx
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [2*WIDTH-1:0] LMASK = ~({(2*WIDTH){1'b1}} << APPROX_COLS);

    logic [1:0]         state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               mode;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] acc_next;
    logic               bit_on;
    logic               last;

    // Partial product for bit cnt; low columns OR-combine, upper columns add with no carry in from column L
    always_comb begin
        bit_on   = state == RUN && b[cnt];
        addend   = {{WIDTH{1'b0}}, a} << cnt;
        sum      = mode ? acc + addend
                        : ((acc | addend) & LMASK) | (((acc & ~LMASK) + (addend & ~LMASK)) & ~LMASK);
        acc_next = bit_on ? sum : acc;
        last     = cnt == LAST || (b >> (32'(cnt) + 1)) == '0;
    end

    assign in_ready     = state == IDLE && !rst;
    assign busy         = state != IDLE;
    assign cg_en_exact  = bit_on;
    assign cg_en_approx = bit_on && !mode && APPROX_COLS > 0;

    // Handshake FSM: accept, iterate until no multiplier bits remain, hold product until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            mode      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a    <= in_a;
                    b    <= in_b;
                    mode <= in_exact;
                    acc  <= '0;
                    cnt  <= '0;
`ifdef ZERO_SKIP_EN
                    if (in_a == '0 || in_b == '0) begin
                        state     <= DONE;
                        out_p     <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
`else
                    state <= RUN;
`endif
                end
                RUN: begin
                    acc <= acc_next;
                    if (last) begin
                        state     <= DONE;
                        out_p     <= acc_next;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
